// File: rtl/ram_burst_reader.sv
// rtl/ram_burst_reader.sv - sequential RAM burst reader with a credit-limited 4-deep output stream FIFO
module ram_burst_reader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  len_r;
  logic [LEN_WIDTH-1:0]  issued_cnt;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic [1:0]            pipe;
  logic [DATA_WIDTH-1:0] fifo [4];
  logic [1:0]            wptr;
  logic [1:0]            rptr;
  logic [2:0]            fcount;
  logic [3:0]            occupancy;
  logic                  can_issue;
  logic                  push;
  logic                  pop;

  // Credits count words already in the FIFO plus reads still in the RAM pipe.
  assign occupancy = {1'b0, fcount} + {3'b0, pipe[0]} + {3'b0, pipe[1]};
  assign can_issue = (state == ISSUE) && (issued_cnt < len_r) && (occupancy < 4'd4);
  assign push      = pipe[1];
  assign pop       = m_valid && m_ready;

  assign m_valid     = (fcount != 3'd0);
  assign m_data      = fifo[rptr];
  assign m_last      = m_valid && (beat_cnt == len_r - LEN_WIDTH'(1));
  assign ram_we      = 1'b0;
  assign ram_data_in = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      ram_addr   <= '0;
      base_addr  <= '0;
      len_r      <= '0;
      issued_cnt <= '0;
      beat_cnt   <= '0;
      pipe       <= 2'b00;
      wptr       <= 2'd0;
      rptr       <= 2'd0;
      fcount     <= 3'd0;
      for (int i = 0; i < 4; i++) fifo[i] <= '0;
    end else begin
      pipe <= {pipe[0], 1'b0};

      if (push) begin
        fifo[wptr] <= ram_data_out;
        wptr       <= wptr + 2'd1;
      end
      if (pop) begin
        rptr     <= rptr + 2'd1;
        beat_cnt <= beat_cnt + LEN_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   fcount <= fcount + 3'd1;
        2'b01:   fcount <= fcount - 3'd1;
        default: fcount <= fcount;
      endcase

      case (state)
        IDLE: begin
          if (start) begin
            base_addr <= start_addr;
            len_r     <= length;
            beat_cnt  <= '0;
            if (length == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              // The first read goes out on the accepting edge so data lands in cycle 2.
              state      <= ISSUE;
              busy       <= 1'b1;
              ram_addr   <= start_addr;
              issued_cnt <= LEN_WIDTH'(1);
              pipe       <= {pipe[0], 1'b1};
            end
          end
        end
        ISSUE: begin
          if (can_issue) begin
            ram_addr   <= base_addr + issued_cnt[ADDR_WIDTH-1:0];
            issued_cnt <= issued_cnt + LEN_WIDTH'(1);
            pipe       <= {pipe[0], 1'b1};
          end
          if (issued_cnt == len_r) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && m_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
- Read-side initiator for the single-port synchronous RAM, which has 1-cycle registered read latency and reads every cycle at the presented address.
- Given a start address and a length, it issues sequential reads, absorbs the RAM latency and returns the words as a valid/ready stream with a last-beat marker.
- Sits between the RAM and downstream consumers (alignment/scoring engines), which may apply backpressure at any cycle.

Parameters:
- ADDR_WIDTH, 12, RAM address width; addresses wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 32, RAM word width.
- LEN_WIDTH, 13, burst length width (ADDR_WIDTH+1, so a full-memory burst is expressible).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  burst request, sampled on rising clk edge.
- start_addr  in  ADDR_WIDTH  first word address.
- length  in  LEN_WIDTH  number of words to read.
- busy  out  1  burst in progress, including drain.
- done  out  1  one-cycle pulse at burst completion.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_we  out  1  RAM write enable, constant 0.
- ram_data_in  out  DATA_WIDTH  RAM write data, constant 0.
- ram_data_out  in  DATA_WIDTH  RAM read data, valid 1 cycle after address.
- m_valid  out  1  stream word valid.
- m_data  out  DATA_WIDTH  stream word.
- m_last  out  1  final word of burst, qualified by m_valid.
- m_ready  in  1  consumer accepts word when m_valid && m_ready.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, ram_addr=0, m_valid=0, m_last=0, m_data=0; FIFO, counters and in-flight pipe cleared.
- States:
  - IDLE: start=1, length>0 → ISSUE (latch start_addr, length); start=1, length=0 → DONE.
  - ISSUE: all reads issued → DRAIN.
  - DRAIN: last beat handshaken → DONE.
  - DONE: lasts 1 cycle (done=1) → IDLE.
- busy=1 in ISSUE and DRAIN. start outside IDLE is ignored.
- Issue rule:
  - A read is issued in a cycle when issued_cnt < length and fifo_count + inflight < 4, both from registered values at cycle start; same-cycle pop is not credited.
  - Issuing drives ram_addr = start_addr + issued_cnt (mod 2^ADDR_WIDTH) as a registered output.
  - A 2-stage valid shift register tracks in-flight reads (address cycle, data cycle); inflight = number of set stages.
  - The RAM word is pushed into the output FIFO at the end of the cycle in which ram_data_out is valid.
  - When not issuing, ram_addr holds its value; the resulting spurious reads are not tracked.
- Output FIFO: fixed depth 4; m_valid = FIFO non-empty; m_data = head; pop on m_valid && m_ready.
  - Simultaneous push and pop are legal, and count is unchanged.
  - The credit rule guarantees no overflow.
- Latency: start in cycle 0 → ram_addr=A in cycle 1 → ram_data_out=mem[A] in cycle 2 → m_valid=1, m_data=mem[A] in cycle 3.
- Throughput: 1 word/cycle sustained while m_ready=1 (steady state fifo_count=1, inflight=2).
- m_last=1 exactly on the beat with index length-1, counted by a beat counter of popped words.
- done pulses in the cycle after the last-beat handshake. For length=0, done pulses in cycle 1 and no beats are produced.
- m_data holds while m_valid && !m_ready; no beat is dropped or duplicated under any m_ready pattern.
- Address arithmetic is ADDR_WIDTH-bit and wraps: 0xFFF → 0x000.
- length=4096 reads the whole memory once.
- Reset mid-burst: the next cycle is IDLE with m_valid=0; in-flight RAM data is discarded; no done pulse.
- ram_we and ram_data_in are always 0.

Test Plan:
- Preload mem[0x010..0x013]=0xA0..0xA3; start_addr=0x010, length=4, m_ready=1 → m_valid cycles 3-6, data A0,A1,A2,A3; m_last only on A3; done in cycle 7; busy cycles 1-6.
- length=0 at start_addr=0x100 → no m_valid; done=1 in cycle 1 only; busy stays 0.
- start_addr=0xFFE, length=4 → ram_addr sequence 0xFFE,0xFFF,0x000,0x001; data order matches mem contents.
- length=8, m_ready toggled 1,0,0,1,0,1,... → all 8 words in order, no loss or duplication; ram_addr issue stalls once fifo_count+inflight=4; m_data stable while stalled.
- Second start pulse in cycle 2 of a length=6 burst → ignored; exactly 6 beats, one done.
- rst asserted in cycle 4 of a length=10 burst → m_valid=0, busy=0 next cycle, no done; a new burst of length 2 afterwards completes normally.
